// File: rtl/countdown_timer.sv
// countdown_timer: BCD HH:MM:SS countdown with a 1 Hz tick enable derived
// from clk_100MHZ. Loads a validated preset, counts down, pauses/resumes,
// and flags expiry.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (reload the last accepted
// preset on expiry and keep running instead of stopping in EXPIRED).
module countdown_timer #(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk_100MHZ,
    input  logic        reset_n,
    input  logic        load,
    input  logic        start_stop,
    input  logic [23:0] preset_bcd,
    output logic [23:0] time_bcd,
    output logic        running,
    output logic        expired,
    output logic        done,
    output logic        load_err,
    output logic        blink
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

    state_t        state_reg;
    logic [PW-1:0] presc_reg;
    logic [23:0]   time_reg;
    logic          running_reg;
    logic          expired_reg;
    logic          done_reg;
    logic          load_err_reg;
    logic          load_prev_reg;
    logic          ss_prev_reg;
    logic          armed_reg;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [23:0]   shadow_reg;
`endif

    // Button events: armed_reg suppresses a level that was already high when
    // reset released, so a press held through reset never fires.
    logic load_ev;
    logic ss_ev;
    assign load_ev = armed_reg && load && !load_prev_reg;
    assign ss_ev   = armed_reg && start_stop && !ss_prev_reg;

    // Per-digit BCD borrow chain for the decrement and digit range checks.
    logic [5:0]  borrow;
    logic [23:0] time_dec;
    logic [5:0]  digit_ok;
    assign borrow[0] = 1'b1;

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        // tens of seconds and tens of minutes wrap to 5, all others to 9
        localparam logic [3:0] WRAP = ((gi == 1) || (gi == 3)) ? 4'd5 : 4'd9;
        logic [3:0] digit;
        assign digit = time_reg[gi*4 +: 4];
        assign time_dec[gi*4 +: 4] = !borrow[gi]      ? digit :
                                     (digit == 4'd0)  ? WRAP  : digit - 4'd1;
        assign digit_ok[gi] = (preset_bcd[gi*4 +: 4] <= 4'd9);
        if (gi < 5) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] && (digit == 4'd0);
        end
    end

    logic preset_ok;
    assign preset_ok = (&digit_ok)
                    && (preset_bcd[15:12] <= 4'd5)
                    && (preset_bcd[7:4]   <= 4'd5)
                    && (preset_bcd[23:20] <= 4'd2)
                    && !((preset_bcd[23:20] == 4'd2) && (preset_bcd[19:16] > 4'd3));

    logic is_zero;
    logic is_one;
    assign is_zero = (time_reg == 24'h000000);
    assign is_one  = (time_reg == 24'h000001);

    // Control FSM, prescaler, time register and registered status outputs.
    always_ff @(posedge clk_100MHZ) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            time_reg      <= '0;
            running_reg   <= 1'b0;
            expired_reg   <= 1'b0;
            done_reg      <= 1'b0;
            load_err_reg  <= 1'b0;
            load_prev_reg <= 1'b0;
            ss_prev_reg   <= 1'b0;
            armed_reg     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_reg    <= '0;
`endif
        end else begin
            armed_reg     <= 1'b1;
            load_prev_reg <= load;
            ss_prev_reg   <= start_stop;
            expired_reg   <= 1'b0;
            load_err_reg  <= 1'b0;
            case (state_reg)
                IDLE, PAUSED, EXPIRED: begin
                    if (load_ev) begin
                        // load wins over a simultaneous start_stop
                        if (preset_ok) begin
                            time_reg  <= preset_bcd;
                            state_reg <= IDLE;
                            done_reg  <= 1'b0;
                            presc_reg <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            shadow_reg <= preset_bcd;
`endif
                        end else begin
                            load_err_reg <= 1'b1;
                        end
                    end else if (ss_ev && (state_reg != EXPIRED) && !is_zero) begin
                        state_reg   <= RUNNING;
                        running_reg <= 1'b1;
                        // a fresh start begins a full second; resume keeps the partial one
                        if (state_reg == IDLE) begin
                            presc_reg <= '0;
                        end
                    end
                end
                RUNNING: begin
                    if (ss_ev) begin
                        state_reg   <= PAUSED;
                        running_reg <= 1'b0;
                    end else if (presc_reg == LAST) begin
                        presc_reg <= '0;
                        if (is_one) begin
                            expired_reg <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            time_reg    <= shadow_reg;
`else
                            time_reg    <= '0;
                            state_reg   <= EXPIRED;
                            running_reg <= 1'b0;
                            done_reg    <= 1'b1;
`endif
                        end else begin
                            time_reg <= time_dec;
                        end
                    end else begin
                        presc_reg <= presc_reg + PW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign time_bcd = time_reg;
    assign running  = running_reg;
    assign expired  = expired_reg;
    assign done     = done_reg;
    assign load_err = load_err_reg;
    assign blink    = running_reg && (presc_reg < HALF);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench. The stimulus process runs a
// seconds-based reference model and queues every expected output change with
// its cycle stamp; an independent monitor pops and compares on each DUT
// output change.
module tb_countdown_timer;
    localparam int TD = 10;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic        start_stop = 1'b0;
    logic [23:0] preset_bcd = '0;
    logic [23:0] time_bcd;
    logic        running, expired, done, load_err, blink;

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk_100MHZ(clk), .reset_n(reset_n), .load(load), .start_stop(start_stop),
        .preset_bcd(preset_bcd), .time_bcd(time_bcd), .running(running),
        .expired(expired), .done(done), .load_err(load_err), .blink(blink)
    );

    typedef struct {
        int          cyc;
        logic [28:0] v;
    } ev_t;
    ev_t q[$];

    int errors = 0;
    int checks = 0;

    // reference model state, in whole seconds and cycles into the second
    int  m_secs = 0, m_phase = 0, m_shadow = 0, m_mode = M_IDLE;
    bit  m_done = 0, m_exp = 0, m_err = 0, m_lprev = 0, m_sprev = 0, m_armed = 0;
    logic [28:0] m_prev_v = '0;
    int  d_cyc = 0;
    logic [23:0] cur_pre = '0;

    function automatic int bcd_to_secs(logic [23:0] b);
        int h, m, s;
        h = int'(b[23:20]) * 10 + int'(b[19:16]);
        m = int'(b[15:12]) * 10 + int'(b[11:8]);
        s = int'(b[7:4]) * 10 + int'(b[3:0]);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [23:0] secs_to_bcd(int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic bit preset_valid(logic [23:0] b);
        for (int i = 0; i < 6; i++) begin
            if (b[i*4 +: 4] > 4'd9) return 0;
        end
        return (int'(b[23:20]) * 10 + int'(b[19:16]) < 24)
            && (int'(b[15:12]) * 10 + int'(b[11:8]) < 60)
            && (int'(b[7:4]) * 10 + int'(b[3:0]) < 60);
    endfunction

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_edge(input bit rn, input bit ld, input bit ss, input logic [23:0] pre);
        bit lev, sev, run_o, blink_o;
        logic [28:0] v;
        if (!rn) begin
            m_secs = 0; m_phase = 0; m_shadow = 0; m_mode = M_IDLE;
            m_done = 0; m_exp = 0; m_err = 0; m_lprev = 0; m_sprev = 0; m_armed = 0;
        end else begin
            lev = m_armed && ld && !m_lprev;
            sev = m_armed && ss && !m_sprev;
            m_lprev = ld; m_sprev = ss; m_armed = 1;
            m_exp = 0; m_err = 0;
            if (m_mode != M_RUN && lev) begin
                if (preset_valid(pre)) begin
                    m_secs = bcd_to_secs(pre); m_shadow = m_secs;
                    m_mode = M_IDLE; m_done = 0; m_phase = 0;
                end else begin
                    m_err = 1;
                end
            end else if (m_mode == M_RUN && sev) begin
                m_mode = M_PAUSE;
            end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && sev && m_secs != 0) begin
                if (m_mode == M_IDLE) m_phase = 0;
                m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (m_phase == TD - 1) begin
                    m_phase = 0;
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_exp = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        m_secs = m_shadow;
`else
                        m_mode = M_EXP;
                        m_done = 1;
`endif
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
            end
        end
        run_o   = (m_mode == M_RUN);
        blink_o = run_o && (m_phase < TD / 2);
        v = {secs_to_bcd(m_secs), run_o, m_exp, m_done, m_err, blink_o};
        if (v != m_prev_v) begin
            q.push_back('{cyc: d_cyc, v: v});
            m_prev_v = v;
        end
    endtask

    task automatic step(input bit rn, input bit ld, input bit ss, input logic [23:0] pre);
        reset_n = rn; load = ld; start_stop = ss; preset_bcd = pre;
        @(posedge clk);
        #1;
        d_cyc++;
        model_edge(rn, ld, ss, pre);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, cur_pre);
    endtask

    task automatic press(input bit ld, input bit ss, input logic [23:0] pre);
        cur_pre = pre;
        step(1, ld, ss, pre);
        step(1, 0, 0, pre);
    endtask

    // Monitor: one comparison per DUT output change, against the queue head.
    logic [28:0] mon_prev = '0;
    logic [28:0] mon_cur;
    int          mon_cyc = 0;
    ev_t         mon_e;
    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            mon_cur = {time_bcd, running, expired, done, load_err, blink};
            if (mon_cur !== mon_prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got=%h expected none", mon_cyc, mon_cur);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != mon_cyc || mon_e.v !== mon_cur) begin
                        errors++;
                        $display("FAIL event got cyc=%0d v=%h expected cyc=%0d v=%h",
                                 mon_cyc, mon_cur, mon_e.cyc, mon_e.v);
                    end else begin
                        $display("ev cyc=%0d time=%h run=%b exp=%b done=%b err=%b blink=%b ok",
                                 mon_cyc, mon_cur[28:5], mon_cur[4], mon_cur[3],
                                 mon_cur[2], mon_cur[1], mon_cur[0]);
                    end
                end
                mon_prev = mon_cur;
            end
        end
    end

    initial begin
        logic [23:0] p;
        int r;
        // reset, then 00:00:05 run to expiry
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0);
        idle(3);
        press(1, 0, 24'h000005);
        press(0, 1, 24'h000005);
        idle(60);
        // full borrow chains
        press(1, 0, 24'h010000);
        press(0, 1, 24'h010000);
        idle(12);
        press(0, 1, 24'h010000);
        press(1, 0, 24'h100000);
        press(0, 1, 24'h100000);
        idle(12);
        press(0, 1, 24'h100000);
        // preset validation
        press(1, 0, 24'h000600);
        press(1, 0, 24'h006000);
        press(1, 0, 24'h240000);
        press(1, 0, 24'h00000a);
        idle(3);
        // pause mid-second and resume
        press(1, 0, 24'h000030);
        step(1, 0, 1, cur_pre);
        idle(13);
        step(1, 0, 1, cur_pre);
        idle(100);
        press(0, 1, cur_pre);
        idle(20);
        // start on zero ignored; simultaneous load+start in IDLE
        for (int i = 0; i < 2; i++) step(0, 0, 0, '0);
        idle(3);
        press(0, 1, 24'h000003);
        idle(3);
        press(1, 1, 24'h000003);
        idle(15);
        // reset while running with start_stop held high
        press(1, 0, 24'h001000);
        press(0, 1, 24'h001000);
        idle(15);
        for (int i = 0; i < 3; i++) step(0, 0, 1, cur_pre);
        for (int i = 0; i < 6; i++) step(1, 0, 1, cur_pre);
        idle(15);
        // randomized phase
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0: p = 24'($urandom);
                1: p = secs_to_bcd($urandom_range(0, 86399));
                default: p = secs_to_bcd($urandom_range(1, 8));
            endcase
            if (r < 4) begin
                step(0, 0, 0, p);
                step(0, 0, 0, p);
            end else if (r < 40) begin
                press(1, 0, p);
            end else if (r < 88) begin
                press(0, 1, p);
            end
            idle($urandom_range(0, 25));
        end
        idle(5);
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event expected cyc=%0d v=%h got no change", mon_e.cyc, mon_e.v);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
